// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: command-driven Gray-code counter sequencer.
// Accepts {start, len, loop} over valid/ready, then presents len+1
// consecutive binary/Gray values. Supports pause, abort, looped replay
// and a one-cycle done pulse after a non-loop run.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high, outputs hold
// RUN    | stepping through the run; rem counts steps still to go
// DONE   | one-cycle pulse state after the last value of a non-loop run

module gray_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_len,
  input  logic         cmd_loop,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         step,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] bin_q,   bin_d;
  logic [N-1:0] gray_q,  gray_d;
  logic [N-1:0] rem_q,   rem_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] len_q,   len_d;
  logic         loop_q,  loop_d;
  logic         step_q,  step_d;
  logic         done_q,  done_d;

  // rem is a down-counter; the run ends when it reaches zero
  logic rem_zero;
  assign rem_zero = (rem_q == '0);

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next-state and next-output decode; every target defaults to hold
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    start_d = start_q;
    len_d   = len_q;
    loop_d  = loop_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          start_d = cmd_start;
          len_d   = cmd_len;
          loop_d  = cmd_loop;
          bin_d   = cmd_start;
          rem_d   = cmd_len;
          step_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pause) begin
          // hold everything; step already defaults low
        end else if (!rem_zero) begin
          bin_d  = bin_q + N'(1);
          rem_d  = rem_q - N'(1);
          step_d = 1'b1;
        end else if (loop_q) begin
          bin_d  = start_q;
          rem_d  = len_q;
          step_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Gray is registered alongside bin so both outputs change on the same edge
    gray_d = bin2gray(bin_d);
  end

  // State and datapath registers; asynchronous reset discards any command
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
      start_q <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
      start_q <= start_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign step      = step_q;
  assign done      = done_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule
